// File: rtl/gpr_writeback_arbiter_pkg.sv
// Shared types and constants for the GPR writeback arbiter and its port-B FIFO.
// The writeback entry is the FIFO payload and the registered write-port image.
package gpr_writeback_arbiter_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // Field is 'rd' rather than 'reg' because reg is a reserved word.
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc8;
    } wb_entry_t;

    function automatic logic is_live_reg(input logic [REG_W-1:0] r);
        return r != REG_ZERO;
    endfunction

endpackage

// File: rtl/gpr_wb_fifo.sv
// Synchronous FIFO of writeback entries; push is ignored when full, pop when empty.
// Head entry is presented combinationally from the read pointer.
module gpr_wb_fifo
    import gpr_writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = count_q == FULL_CNT;
    assign empty   = count_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/gpr_writeback_arbiter.sv
// Single write-port master for the GPR file: merges in-order pipeline results (port A)
// with buffered long-latency results (port B) and tracks pending port-B writes per register.
module gpr_writeback_arbiter
    import gpr_writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              aValid,
    input  logic [REG_W-1:0]  aReg,
    input  logic [DATA_W-1:0] aData,
    input  logic [DATA_W-1:0] aPc8,
    output logic              stallA,
    input  logic              bValid,
    output logic              bReady,
    input  logic [REG_W-1:0]  bReg,
    input  logic [DATA_W-1:0] bData,
    input  logic [DATA_W-1:0] bPc8,
    input  logic              issueValid,
    input  logic [REG_W-1:0]  issueReg,
    output logic              issueReady,
    input  logic [REG_W-1:0]  queryReg1,
    input  logic [REG_W-1:0]  queryReg2,
    output logic              busy1,
    output logic              busy2,
    output logic [REG_W-1:0]  wr,
    output logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] pc8,
    output logic              wrEnable
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wb_entry_t a_entry;
    wb_entry_t b_entry;
    wb_entry_t head;
    wb_entry_t wb_d;
    wb_entry_t wb_q;
    logic      we_d;
    logic      we_q;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic a_win;

    logic [STARVE_W-1:0] starve_d;
    logic [STARVE_W-1:0] starve_q;
    logic                stall_d;
    logic                stall_q;

    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    assign a_entry = '{rd: aReg, data: aData, pc8: aPc8};
    assign b_entry = '{rd: bReg, data: bData, pc8: bPc8};

    assign a_win  = aValid && is_live_reg(aReg);
    assign bReady = !fifo_full;
    // $0 results are handshaken but never stored.
    assign push   = bValid && !fifo_full && is_live_reg(bReg);
    assign pop    = !a_win && !fifo_empty;

    gpr_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_data(b_entry),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        wb_d = wb_q;
        we_d = 1'b0;
        if (a_win) begin
            wb_d = a_entry;
            we_d = 1'b1;
        end else if (pop) begin
            wb_d = head;
            we_d = 1'b1;
        end
    end

    // Saturating at the limit keeps stallA asserted if upstream ignores it.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (a_win && starve_q != STARVE_MAX) begin
            starve_d = starve_q + STARVE_W'(1);
        end
        stall_d = starve_d == STARVE_MAX;
    end

    assign issueReady = cnt_q[issueReg] != CNT_MAX;
    assign busy1      = cnt_q[queryReg1] != '0;
    assign busy2      = cnt_q[queryReg2] != '0;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issueValid && issueReady && is_live_reg(issueReg)) begin
            inc_vec[issueReg] = 1'b1;
        end
        if (pop && cnt_q[head.rd] != '0) begin
            dec_vec[head.rd] = 1'b1;
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_vec[r] && !inc_vec[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
        // Slot 0 exists only so lookups need no special case.
        cnt_d[0] = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_q     <= '0;
            we_q     <= 1'b0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            wb_q     <= wb_d;
            we_q     <= we_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign wr       = wb_q.rd;
    assign wrData   = wb_q.data;
    assign pc8      = wb_q.pc8;
    assign wrEnable = we_q;
    assign stallA   = stall_q;

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Scenario bench for gpr_writeback_arbiter: expected writes are queued as stimulus is driven
// and consumed whenever the write port fires.
module tb_gpr_writeback_arbiter;
    import gpr_writeback_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        aValid;
    logic [4:0]  aReg;
    logic [31:0] aData;
    logic [31:0] aPc8;
    logic        stallA;
    logic        bValid;
    logic        bReady;
    logic [4:0]  bReg;
    logic [31:0] bData;
    logic [31:0] bPc8;
    logic        issueValid;
    logic [4:0]  issueReg;
    logic        issueReady;
    logic [4:0]  queryReg1;
    logic [4:0]  queryReg2;
    logic        busy1;
    logic        busy2;
    logic [4:0]  wr;
    logic [31:0] wrData;
    logic [31:0] pc8;
    logic        wrEnable;

    int checks   = 0;
    int failures = 0;
    wb_entry_t exp_q [$];

    gpr_writeback_arbiter #(
        .DEPTH       (4),
        .CNT_W       (2),
        .STARVE_LIMIT(8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .aValid    (aValid),
        .aReg      (aReg),
        .aData     (aData),
        .aPc8      (aPc8),
        .stallA    (stallA),
        .bValid    (bValid),
        .bReady    (bReady),
        .bReg      (bReg),
        .bData     (bData),
        .bPc8      (bPc8),
        .issueValid(issueValid),
        .issueReg  (issueReg),
        .issueReady(issueReady),
        .queryReg1 (queryReg1),
        .queryReg2 (queryReg2),
        .busy1     (busy1),
        .busy2     (busy2),
        .wr        (wr),
        .wrData    (wrData),
        .pc8       (pc8),
        .wrEnable  (wrEnable)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        aValid = 1'b0; aReg = '0; aData = '0; aPc8 = '0;
        bValid = 1'b0; bReg = '0; bData = '0; bPc8 = '0;
        issueValid = 1'b0; issueReg = '0;
        queryReg1 = '0; queryReg2 = '0;
    endtask

    task automatic expect_write(input logic [4:0] r, input logic [31:0] d, input logic [31:0] p);
        wb_entry_t e;
        e.rd = r; e.data = d; e.pc8 = p;
        exp_q.push_back(e);
    endtask

    // Advance one clock and score any write that appeared on the port.
    task automatic tick();
        wb_entry_t e;
        @(posedge clock);
        #1;
        if (wrEnable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got wr=%0d data=%h pc8=%h, required no write",
                         wr, wrData, pc8);
            end else begin
                e = exp_q.pop_front();
                if (wr !== e.rd || wrData !== e.data || pc8 !== e.pc8) begin
                    failures++;
                    $display("FAIL write_payload got wr=%0d data=%h pc8=%h, required wr=%0d data=%h pc8=%h",
                             wr, wrData, pc8, e.rd, e.data, e.pc8);
                end
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #3;
        checks++;
        if ({wrEnable, wr, wrData, pc8, stallA} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got we=%b wr=%0d data=%h pc8=%h stall=%b, required all 0",
                     wrEnable, wr, wrData, pc8, stallA);
        end
        checks++;
        if (bReady !== 1'b1 || issueReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got bReady=%b issueReady=%b, required 1 1", bReady, issueReady);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_port_a();
        aValid = 1'b1; aReg = 5'd5; aData = 32'h1234; aPc8 = 32'h3008;
        expect_write(5'd5, 32'h1234, 32'h3008);
        tick();
        idle_inputs();
        checks++;
        if (wrEnable !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL porta_latency got we=%b pending=%0d, required we=1 pending=0",
                     wrEnable, exp_q.size());
        end
        tick();
        checks++;
        if (wrEnable !== 1'b0) begin
            failures++;
            $display("FAIL porta_single_pulse got we=%b, required 0", wrEnable);
        end
    endtask

    task automatic test_port_b();
        queryReg1 = 5'd9;
        issueValid = 1'b1; issueReg = 5'd9;
        tick();
        issueValid = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_issue got %b, required 1", busy1);
        end
        bValid = 1'b1; bReg = 5'd9; bData = 32'hAA; bPc8 = 32'h4008;
        expect_write(5'd9, 32'hAA, 32'h4008);
        tick();
        bValid = 1'b0;
        checks++;
        if (wrEnable !== 1'b0 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL portb_one_cycle got we=%b busy=%b, required we=0 busy=1", wrEnable, busy1);
        end
        tick();
        checks++;
        if (wrEnable !== 1'b1 || busy1 !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL portb_two_cycles got we=%b busy=%b pending=%0d, required 1 0 0",
                     wrEnable, busy1, exp_q.size());
        end
        idle_inputs();
    endtask

    task automatic test_starve();
        int stall_seen = 0;
        int stall_at   = -1;
        for (int i = 0; i < 20; i++) begin
            bValid = (i == 0); bReg = 5'd12; bData = 32'hB00C; bPc8 = 32'h5008;
            if (stallA === 1'b1) begin
                stall_seen++;
                if (stall_at < 0) stall_at = i;
                aValid = 1'b0;
                expect_write(5'd12, 32'hB00C, 32'h5008);
            end else begin
                aValid = 1'b1; aReg = 5'(16 + (i % 8));
                aData = 32'h1000 + 32'(i); aPc8 = 32'h2000 + 32'(4 * i);
                expect_write(aReg, aData, aPc8);
            end
            tick();
        end
        idle_inputs();
        tick();
        checks++;
        if (stall_seen != 1 || stall_at != 9) begin
            failures++;
            $display("FAIL starve_pulse got count=%0d at_cycle=%0d, required count=1 at_cycle=9",
                     stall_seen, stall_at);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL starve_drain got pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 5; i++) begin
            aValid = 1'b1; aReg = 5'(24 + i); aData = 32'hA0 + 32'(i); aPc8 = 32'h6000 + 32'(i);
            bValid = 1'b1; bReg = 5'(1 + i); bData = 32'hB0 + 32'(i); bPc8 = 32'h7000 + 32'(i);
            expect_write(aReg, aData, aPc8);
            #1;
            if (i == 3) begin
                checks++;
                if (bReady !== 1'b1) begin
                    failures++;
                    $display("FAIL fifo_not_yet_full got bReady=%b, required 1", bReady);
                end
            end
            if (i == 4) begin
                checks++;
                if (bReady !== 1'b0) begin
                    failures++;
                    $display("FAIL fifo_full_ready got bReady=%b, required 0", bReady);
                end
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            expect_write(5'(1 + i), 32'hB0 + 32'(i), 32'h7000 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (wrEnable !== 1'b1) begin
                failures++;
                $display("FAIL fifo_drain_consecutive step=%0d got we=%b, required 1", i, wrEnable);
            end
        end
        tick();
        checks++;
        if (wrEnable !== 1'b0 || bReady !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL fifo_drained got we=%b bReady=%b pending=%0d, required 0 1 0",
                     wrEnable, bReady, exp_q.size());
        end
    endtask

    task automatic test_reg_zero();
        aValid = 1'b1; aReg = 5'd0; aData = 32'hDEAD; aPc8 = 32'h8000;
        bValid = 1'b1; bReg = 5'd0; bData = 32'hBEEF; bPc8 = 32'h9000;
        issueValid = 1'b1; issueReg = 5'd0; queryReg1 = 5'd0;
        #1;
        checks++;
        if (bReady !== 1'b1) begin
            failures++;
            $display("FAIL zero_bready got %b, required 1", bReady);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (wrEnable !== 1'b0 || busy1 !== 1'b0) begin
                failures++;
                $display("FAIL zero_no_write cycle=%0d got we=%b busy=%b, required 0 0",
                         i, wrEnable, busy1);
            end
        end
        idle_inputs();
        tick();
        tick();
        checks++;
        if (wrEnable !== 1'b0 || bReady !== 1'b1) begin
            failures++;
            $display("FAIL zero_fifo_empty got we=%b bReady=%b, required 0 1", wrEnable, bReady);
        end
    endtask

    task automatic test_reset_midop();
        queryReg1 = 5'd3; queryReg2 = 5'd7;
        for (int i = 0; i < 5; i++) begin
            aValid = 1'b1; aReg = 5'(10 + i); aData = 32'hC0 + 32'(i); aPc8 = 32'hA000 + 32'(i);
            bValid = (i < 3); bReg = (i < 2) ? 5'd7 : 5'd8; bData = 32'hD0 + 32'(i); bPc8 = '0;
            issueValid = 1'b1; issueReg = (i < 2) ? 5'd7 : 5'd3;
            expect_write(aReg, aData, aPc8);
            tick();
        end
        issueValid = 1'b0; bValid = 1'b0; issueReg = 5'd3;
        #1;
        checks++;
        if (issueReady !== 1'b0 || busy1 !== 1'b1 || busy2 !== 1'b1) begin
            failures++;
            $display("FAIL pending_saturate got issueReady=%b busy1=%b busy2=%b, required 0 1 1",
                     issueReady, busy1, busy2);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({wrEnable, wr, wrData, pc8, stallA} !== '0) begin
            failures++;
            $display("FAIL midop_reset_outputs got we=%b wr=%0d data=%h pc8=%h stall=%b, required 0",
                     wrEnable, wr, wrData, pc8, stallA);
        end
        checks++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0 || bReady !== 1'b1 || issueReady !== 1'b1) begin
            failures++;
            $display("FAIL midop_reset_state got busy1=%b busy2=%b bReady=%b issueReady=%b, required 0 0 1 1",
                     busy1, busy2, bReady, issueReady);
        end
        idle_inputs();
        queryReg2 = 5'd7;
        #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checks++;
        if (wrEnable !== 1'b0 || busy2 !== 1'b0 || bReady !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL after_reset got we=%b busy2=%b bReady=%b pending=%0d, required 0 0 1 0",
                     wrEnable, busy2, bReady, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_port_a();
        test_port_b();
        test_starve();
        test_fifo_full();
        test_reg_zero();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
